// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - state encoding and constants for the MEM-stage data-memory sequencer
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } dmem_state_e;

  localparam logic [1:0] RESULTSRC_MEM = 2'b01;

  localparam int DMEM_ADDR_WIDTH      = 32;
  localparam int DMEM_DATA_WIDTH      = 32;
  localparam int DMEM_RESULTSRC_WIDTH = 2;
  localparam int DMEM_TIMEOUT_CYCLES  = 16;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// rtl/dmem_timeout_cnt.sv - bus watchdog counter, used only when DMEM_CTRL_TIMEOUT_EN is defined
module dmem_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store sequencer for a req/gnt/rvalid data bus
// Optional watchdog abort is built when DMEM_CTRL_TIMEOUT_EN is defined.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DMEM_DATA_WIDTH,
  parameter int RESULTSRC_WIDTH = DMEM_RESULTSRC_WIDTH,
  parameter int TIMEOUT_CYCLES  = DMEM_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RESULTSRC_WIDTH-1:0] ResultSrc_M,
  input  logic                       MemWrite_M,
  input  logic [ADDR_WIDTH-1:0]      ALU_result_M,
  input  logic [DATA_WIDTH-1:0]      WriteData_M,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       stall_M,
  output logic [DATA_WIDTH-1:0]      ReadData_M,
  output logic                       rdata_valid_M,
  output logic                       misalign_err,
  output logic                       bus_err
);

  dmem_state_e state_q, state_d;
  logic        access;
  logic        aligned;
  logic        start;
  logic        stall_q;
  logic        timeout;
  logic        abort;

  assign access  = MemWrite_M | (ResultSrc_M == RESULTSRC_WIDTH'(RESULTSRC_MEM));
  assign aligned = (ALU_result_M[1:0] == 2'b00);
  assign start   = (state_q == IDLE) && access && aligned;

  // abort = watchdog fired with no handshake arriving in the same cycle
  assign abort = timeout &&
                 (((state_q == REQ) && !mem_gnt) || ((state_q == WAIT_R) && !mem_rvalid));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ: begin
        if (mem_gnt)    state_d = mem_we ? DONE : WAIT_R;
        else if (abort) state_d = DONE;
      end
      WAIT_R:  if (mem_rvalid || abort) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      stall_q       <= 1'b0;
      rdata_valid_M <= 1'b0;
      misalign_err  <= 1'b0;
      ReadData_M    <= '0;
    end else begin
      mem_req       <= (state_d == REQ);
      stall_q       <= (state_d == REQ) || (state_d == WAIT_R);
      rdata_valid_M <= (state_d == DONE) && !mem_we;
      misalign_err  <= (state_q == IDLE) && access && !aligned;
      if (start) begin
        mem_we    <= MemWrite_M;
        mem_addr  <= {ALU_result_M[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata <= WriteData_M;
      end
      if ((state_q == WAIT_R) && mem_rvalid) begin
        ReadData_M <= mem_rdata;
      end else if (abort) begin
        ReadData_M <= '0;
      end
    end
  end

  // Only the IDLE detect term is combinational; reset masks it so a held access cannot stall.
  assign stall_M = stall_q | (start & rst_n);

`ifdef DMEM_CTRL_TIMEOUT_EN
  logic cnt_clear;
  logic cnt_enable;

  assign cnt_clear  = (state_d != state_q) && ((state_d == REQ) || (state_d == WAIT_R));
  assign cnt_enable = (state_q == REQ) || (state_q == WAIT_R);

  dmem_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= abort;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus_err            = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - randomized bench for dmem_access_ctrl against a transaction-level model
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ResultSrc_M = 2'b00;
  logic        MemWrite_M = 1'b0;
  logic [31:0] ALU_result_M = '0;
  logic [31:0] WriteData_M = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_M;
  logic [31:0] ReadData_M;
  logic        rdata_valid_M, misalign_err, bus_err;

  dmem_access_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESULTSRC_WIDTH(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M),
    .ALU_result_M(ALU_result_M), .WriteData_M(WriteData_M), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall_M(stall_M),
    .ReadData_M(ReadData_M), .rdata_valid_M(rdata_valid_M),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int req_cycles = 0, exp_req_cycles = 0;
  int mis_pulses = 0, exp_mis = 0;
  int berr_pulses = 0, exp_berr = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req)      req_cycles++;
      if (misalign_err) mis_pulses++;
      if (bus_err)      berr_pulses++;
    end
  end

  // One MEM-stage instruction; bus grants after g refused REQ cycles, data after r wait cycles.
  task automatic run_instr(input logic st, input logic ld, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
    logic acc, load, ok, granted;
    int   exp_stall, n, reqc, waitc, v;
    acc  = st | ld;
    load = ld & ~st;
    ok   = acc && (addr[1:0] == 2'b00);
    exp_stall = ok ? (1 + (g + 1) + (load ? r : 0)) : 0;
    if (ok) exp_req_cycles += g + 1;
    if (acc && !ok) exp_mis++;
    if (ok && load) model_rdata = rd;

    @(negedge clk);
    v = $urandom_range(0, 2);
    MemWrite_M   = st;
    ResultSrc_M  = ld ? 2'b01 : ((v == 0) ? 2'b00 : 2'(v + 1));
    ALU_result_M = addr;
    WriteData_M  = wd;
    mem_gnt      = 1'($urandom);
    mem_rvalid   = 1'($urandom);
    mem_rdata    = $urandom;
    #1;
    n = 0; reqc = 0; waitc = 0; granted = 1'b0;
    while (stall_M && n < 300) begin
      n++;
      if (mem_req) begin
        reqc++;
        check("req_addr", mem_addr, {addr[31:2], 2'b00});
        check("req_we", mem_we, st);
        if (st) check("req_wdata", mem_wdata, wd);
        mem_gnt    = (reqc > g);
        granted    = granted | mem_gnt;
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
      end else if (granted) begin
        waitc++;
        mem_gnt    = 1'($urandom);
        mem_rvalid = (waitc >= r);
        mem_rdata  = mem_rvalid ? rd : $urandom;
      end
      @(negedge clk);
      #1;
    end
    check("stall_len", n, exp_stall);
    check("rdata_valid", rdata_valid_M, ok && load);
    check("read_data", ReadData_M, model_rdata);
    mem_gnt    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int kind;
    logic [31:0] a;

    #12;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_stall", stall_M, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rdata", ReadData_M, 32'h0);
    check("rst_rvalid_m", rdata_valid_M, 1'b0);
    check("rst_misalign", misalign_err, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1);
    run_instr(1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h1234_5678, 2, 3);
    run_instr(1'b0, 1'b1, 32'h0000_0022, 32'h0, 32'h0, 0, 1);
    run_instr(1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'hA5A5_0001, 0, 1);
    run_instr(1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'h5A5A_0002, 0, 1);
    run_instr(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1, 1);

    // reset while waiting for load data
    @(negedge clk);
    MemWrite_M = 1'b0; ResultSrc_M = 2'b01; ALU_result_M = 32'h40;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    exp_req_cycles += 1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("wait_r_stall", stall_M, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_stall", stall_M, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ResultSrc_M = 2'b00;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0_0BAD;
    model_rdata = '0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check("spur_stall", stall_M, 1'b0);
    check("spur_req", mem_req, 1'b0);
    check("spur_valid", rdata_valid_M, 1'b0);
    check("spur_rdata", ReadData_M, model_rdata);

`ifdef DMEM_CTRL_TIMEOUT_EN
    begin
      int n;
      @(negedge clk);
      MemWrite_M = 1'b0; ResultSrc_M = 2'b01; ALU_result_M = 32'h80;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      n = 0;
      while (stall_M && n < 100) begin
        n++;
        @(negedge clk);
        #1;
      end
      exp_req_cycles += 16;
      exp_berr++;
      model_rdata = '0;
      check("to_stall_len", n, 17);
      check("to_bus_err", bus_err, 1'b1);
      check("to_rdata", ReadData_M, model_rdata);
    end
`endif

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom & 32'hFFFF_FFFC;
      case (kind)
        0, 1:    run_instr(1'b0, 1'b0, $urandom, $urandom, $urandom, 0, 1);
        2:       run_instr(1'(kind[0]), 1'b1, a | 32'($urandom_range(1, 3)), $urandom, $urandom, 0, 1);
        3, 4, 5: run_instr(1'b1, 1'b0, a, $urandom, $urandom, $urandom_range(0, 3), 1);
        9:       run_instr(1'b1, 1'b1, a, $urandom, $urandom, $urandom_range(0, 3), 1);
        default: run_instr(1'b0, 1'b1, a, $urandom, $urandom,
                           $urandom_range(0, 3), $urandom_range(1, 4));
      endcase
    end

    @(negedge clk);
    MemWrite_M = 1'b0; ResultSrc_M = 2'b00;
    @(negedge clk);
    #1;
    check("req_cycle_total", req_cycles, exp_req_cycles);
    check("misalign_total", mis_pulses, exp_mis);
    check("bus_err_total", berr_pulses, exp_berr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
